// File: rtl/stream_dwc_pkg.sv
// Shared types and elaboration-time helpers for the stream width converter.
// Mode, ratio and counter width are all derived from the two TDATA widths.
package stream_dwc_pkg;

    typedef enum logic [1:0] {DWC_EQ, DWC_DOWN, DWC_UP} dwc_mode_e;

    function automatic dwc_mode_e dwc_mode(input int in_w, input int out_w);
        if (in_w > out_w) return DWC_DOWN;
        if (out_w > in_w) return DWC_UP;
        return DWC_EQ;
    endfunction

    function automatic int dwc_ratio(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    function automatic bit dwc_legal(input int in_w, input int out_w);
        return (in_w > out_w) ? ((in_w % out_w) == 0) : ((out_w % in_w) == 0);
    endfunction

    // ceil(log2(v)), never below 1 so a ratio of 1 still yields a usable vector
    function automatic int dwc_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_width_converter_ctr.sv
// Modulo-R beat counter shared by the split and pack datapaths.
// clr has priority over inc; the count wraps R-1 -> 0 on inc.
module dwc_beat_ctr #(
    parameter int R  = 3,
    parameter int CW = 2
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          is_last
);
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)      cnt_d = '0;
        else if (inc) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign is_last = (cnt_q == LAST);
endmodule

// File: rtl/stream_width_converter.sv
// AXI-Stream width converter: splits (IN > OUT), packs (OUT > IN) or re-registers (equal)
// beats, always LSB chunk first, one narrow-side beat per cycle.
module stream_width_converter
    import stream_dwc_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
    input  logic                 in0_V_TVALID,
    output logic                 in0_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_TDATA,
    output logic                 out_V_TVALID,
    input  logic                 out_V_TREADY,
    output logic [dwc_clog2(dwc_ratio(IN_WIDTH, OUT_WIDTH))-1:0] beat_idx
);
    localparam dwc_mode_e MODE = dwc_mode(IN_WIDTH, OUT_WIDTH);
    localparam int        R    = dwc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int        CW   = dwc_clog2(R);

    if (!dwc_legal(IN_WIDTH, OUT_WIDTH)) begin : g_illegal
        $error("stream_width_converter: widths %0d/%0d are not integer multiples", IN_WIDTH, OUT_WIDTH);
    end

    if (MODE == DWC_DOWN) begin : g_down
        typedef enum logic {D_EMPTY, D_EMIT} down_state_e;
        down_state_e         state_q, state_d;
        logic [IN_WIDTH-1:0] data_q, data_d;
        logic                valid_q, valid_d;
        logic                in_rdy, in_fire, out_fire, is_last;
        logic [CW-1:0]       cnt;

        dwc_beat_ctr #(.R(R), .CW(CW)) u_ctr (
            .ap_clk(ap_clk), .ap_rst(ap_rst), .inc(out_fire), .clr(in_fire),
            .cnt(cnt), .is_last(is_last)
        );

        always_comb begin
            // the last chunk leaving frees the register, so a new word may load in the same cycle
            in_rdy   = !ap_rst && ((state_q == D_EMPTY) || (is_last && out_V_TREADY));
            in_fire  = in0_V_TVALID && in_rdy;
            out_fire = valid_q && out_V_TREADY;
            state_d  = state_q;
            data_d   = data_q;
            valid_d  = valid_q;
            case (state_q)
                D_EMPTY: if (in_fire) begin
                    data_d  = in0_V_TDATA;
                    valid_d = 1'b1;
                    state_d = D_EMIT;
                end
                D_EMIT: if (out_fire) begin
                    if (!is_last)     data_d = data_q >> OUT_WIDTH;
                    else if (in_fire) data_d = in0_V_TDATA;
                    else begin
                        valid_d = 1'b0;
                        state_d = D_EMPTY;
                    end
                end
                default: state_d = D_EMPTY;
            endcase
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state_q <= D_EMPTY;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in0_V_TREADY = in_rdy;
        assign out_V_TDATA  = data_q[OUT_WIDTH-1:0];
        assign out_V_TVALID = valid_q;
        assign beat_idx     = cnt;
    end else if (MODE == DWC_UP) begin : g_up
        typedef enum logic {U_FILL, U_HOLD} up_state_e;
        up_state_e            state_q, state_d;
        logic [OUT_WIDTH-1:0] data_q, data_d;
        logic                 valid_q, valid_d;
        logic                 in_rdy, in_fire, out_fire, is_last;
        logic [CW-1:0]        cnt;

        dwc_beat_ctr #(.R(R), .CW(CW)) u_ctr (
            .ap_clk(ap_clk), .ap_rst(ap_rst), .inc(in_fire), .clr(1'b0),
            .cnt(cnt), .is_last(is_last)
        );

        always_comb begin
            in_rdy   = !ap_rst && ((state_q == U_FILL) || out_V_TREADY);
            in_fire  = in0_V_TVALID && in_rdy;
            out_fire = valid_q && out_V_TREADY;
            state_d  = state_q;
            data_d   = data_q;
            valid_d  = valid_q;
            // slot 0 starts a fresh word; in HOLD this only happens alongside the output leaving
            if (in_fire) begin
                if (cnt == '0) data_d = '0;
                data_d[int'(cnt)*IN_WIDTH +: IN_WIDTH] = in0_V_TDATA;
            end
            case (state_q)
                U_FILL: if (in_fire && is_last) begin
                    valid_d = 1'b1;
                    state_d = U_HOLD;
                end
                U_HOLD: if (out_fire) begin
                    valid_d = 1'b0;
                    state_d = U_FILL;
                end
                default: state_d = U_FILL;
            endcase
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state_q <= U_FILL;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in0_V_TREADY = in_rdy;
        assign out_V_TDATA  = data_q;
        assign out_V_TVALID = valid_q;
        assign beat_idx     = cnt;
    end else begin : g_eq
        logic [IN_WIDTH-1:0] data_q, data_d;
        logic                valid_q, valid_d;
        logic                in_rdy, in_fire;

        always_comb begin
            in_rdy  = !ap_rst && (!valid_q || out_V_TREADY);
            in_fire = in0_V_TVALID && in_rdy;
            data_d  = data_q;
            valid_d = valid_q;
            if (in_fire) begin
                data_d  = in0_V_TDATA;
                valid_d = 1'b1;
            end else if (out_V_TREADY) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign in0_V_TREADY = in_rdy;
        assign out_V_TDATA  = data_q;
        assign out_V_TVALID = valid_q;
        assign beat_idx     = '0;
    end
endmodule

// File: tb/tb_stream_width_converter.sv
// Directed bench for the width converter: 24->8 split, 8->24 pack and 24->24 slice.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_stream_width_converter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [23:0] d_in_data;  logic d_in_valid, d_in_ready;
    logic [7:0]  d_out_data; logic d_out_valid, d_out_ready;
    logic [1:0]  d_idx;

    logic [7:0]  u_in_data;  logic u_in_valid, u_in_ready;
    logic [23:0] u_out_data; logic u_out_valid, u_out_ready;
    logic [1:0]  u_idx;

    logic [23:0] e_in_data;  logic e_in_valid, e_in_ready;
    logic [23:0] e_out_data; logic e_out_valid, e_out_ready;
    logic [0:0]  e_idx;

    stream_width_converter #(.IN_WIDTH(24), .OUT_WIDTH(8)) u_down (
        .ap_clk(clk), .ap_rst(rst),
        .in0_V_TDATA(d_in_data), .in0_V_TVALID(d_in_valid), .in0_V_TREADY(d_in_ready),
        .out_V_TDATA(d_out_data), .out_V_TVALID(d_out_valid), .out_V_TREADY(d_out_ready),
        .beat_idx(d_idx)
    );

    stream_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(24)) u_up (
        .ap_clk(clk), .ap_rst(rst),
        .in0_V_TDATA(u_in_data), .in0_V_TVALID(u_in_valid), .in0_V_TREADY(u_in_ready),
        .out_V_TDATA(u_out_data), .out_V_TVALID(u_out_valid), .out_V_TREADY(u_out_ready),
        .beat_idx(u_idx)
    );

    stream_width_converter #(.IN_WIDTH(24), .OUT_WIDTH(24)) u_eq (
        .ap_clk(clk), .ap_rst(rst),
        .in0_V_TDATA(e_in_data), .in0_V_TVALID(e_in_valid), .in0_V_TREADY(e_in_ready),
        .out_V_TDATA(e_out_data), .out_V_TVALID(e_out_valid), .out_V_TREADY(e_out_ready),
        .beat_idx(e_idx)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0]  down_exp [6] = '{8'hC3, 8'hB2, 8'hA1, 8'h33, 8'h22, 8'h11};
    logic [7:0]  post_rst [3] = '{8'h66, 8'h55, 8'h44};
    logic [23:0] words [$];
    logic [7:0]  exp_q [$];
    logic [23:0] eq_vals [8];
    logic [23:0] w;
    logic [7:0]  held_data;
    logic        held, hs;
    int          got, total, cyc, sb;

    initial begin
        rst = 1'b1;
        d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b1;
        u_in_valid = 1'b0; u_in_data = '0; u_out_ready = 1'b1;
        e_in_valid = 1'b0; e_in_data = '0; e_out_ready = 1'b1;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", d_out_valid, 1'b0);
            chk("rst_data",  d_out_data, 8'h00);
            chk("rst_ready", d_in_ready, 1'b0);
            chk("rst_idx",   d_idx, 2'd0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rel_down_ready", d_in_ready, 1'b1);
        chk("rel_up_ready",   u_in_ready, 1'b1);
        chk("rel_eq_ready",   e_in_ready, 1'b1);
        chk("rel_valid",      d_out_valid, 1'b0);

        // split two back-to-back words with the sink always ready
        step();
        d_in_valid = 1'b1; d_in_data = 24'hA1B2C3;
        @(negedge clk);
        chk("down_ready_idle", d_in_ready, 1'b1);
        step();
        d_in_data = 24'h112233;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("down_valid", d_out_valid, 1'b1);
            chk("down_data",  d_out_data, down_exp[i]);
            chk("down_idx",   d_idx, 32'(i % 3));
            chk("down_in_ready", d_in_ready, 32'((i % 3) == 2));
            step();
            if (i == 2) d_in_valid = 1'b0;
        end
        @(negedge clk);
        chk("down_drain", d_out_valid, 1'b0);

        // random backpressure on the split path with a reference queue of chunks
        words.push_back(24'hA1B2C3);
        words.push_back(24'h112233);
        for (int i = 0; i < 60; i++) words.push_back(24'($urandom));
        foreach (words[k]) begin
            exp_q.push_back(words[k][7:0]);
            exp_q.push_back(words[k][15:8]);
            exp_q.push_back(words[k][23:16]);
        end
        total = exp_q.size();
        step();
        d_out_ready = 1'b1;
        fork
            begin
                sb = 0;
                foreach (words[k]) begin
                    d_in_valid = 1'b1;
                    d_in_data  = words[k];
                    do begin
                        @(negedge clk);
                        hs = d_in_ready;
                        step();
                        sb++;
                    end while (!hs && sb < 6000);
                end
                d_in_valid = 1'b0;
            end
            begin
                got = 0; cyc = 0; held = 1'b0; held_data = '0;
                while (got < total && cyc < 6000) begin
                    @(negedge clk);
                    if (held) begin
                        chk("bp_hold_valid", d_out_valid, 1'b1);
                        chk("bp_hold_data",  d_out_data, held_data);
                    end
                    if (d_out_valid && d_out_ready) begin
                        chk("bp_data", d_out_data, exp_q.pop_front());
                        got++;
                        held = 1'b0;
                    end else if (d_out_valid) begin
                        held = 1'b1;
                        held_data = d_out_data;
                    end else begin
                        held = 1'b0;
                    end
                    step();
                    d_out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                end
                chk("bp_count", got, total);
            end
        join
        d_out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("bp_idle", d_out_valid, 1'b0);

        // pack six bytes into two words, sink ready
        step();
        for (int i = 0; i < 6; i++) begin
            u_in_valid = 1'b1;
            u_in_data  = 8'(i + 1);
            @(negedge clk);
            chk("up_ready", u_in_ready, 1'b1);
            chk("up_idx",   u_idx, 32'(i % 3));
            chk("up_valid", u_out_valid, 32'(i == 3));
            if (i == 3) chk("up_word0", u_out_data, 24'h030201);
            step();
        end
        u_in_valid = 1'b0;
        @(negedge clk);
        chk("up_valid1", u_out_valid, 1'b1);
        chk("up_word1",  u_out_data, 24'h060504);
        step();
        @(negedge clk);
        chk("up_drain", u_out_valid, 1'b0);

        // pack with the sink stalled: ready must drop after the third beat
        step();
        u_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            u_in_valid = 1'b1;
            u_in_data  = 8'(7 + i);
            @(negedge clk);
            chk("upbp_ready", u_in_ready, 1'b1);
            chk("upbp_idx",   u_idx, 32'(i));
            step();
        end
        u_in_data = 8'h0A;
        @(negedge clk);
        chk("upbp_valid", u_out_valid, 1'b1);
        chk("upbp_word",  u_out_data, 24'h090807);
        chk("upbp_stall", u_in_ready, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("upbp_held",  u_out_data, 24'h090807);
        chk("upbp_idx0",  u_idx, 2'd0);
        chk("upbp_stall2", u_in_ready, 1'b0);
        u_out_ready = 1'b1;
        #1;
        chk("upbp_release", u_in_ready, 1'b1);
        step();
        u_in_valid = 1'b0;
        @(negedge clk);
        chk("upbp_after_valid", u_out_valid, 1'b0);
        chk("upbp_after_idx",   u_idx, 2'd1);

        // reset in the middle of a split word
        step();
        d_out_ready = 1'b1;
        d_in_valid = 1'b1; d_in_data = 24'hA1B2C3;
        step();
        d_in_valid = 1'b0;
        @(negedge clk);
        chk("mid_first", d_out_data, 8'hC3);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", d_out_valid, 1'b0);
        chk("mid_rst_idx",   d_idx, 2'd0);
        chk("mid_rst_ready", d_in_ready, 1'b0);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_valid", d_out_valid, 1'b0);
        chk("mid_rel_idx",   d_idx, 2'd0);
        chk("mid_rel_ready", d_in_ready, 1'b1);
        chk("mid_up_idx",    u_idx, 2'd0);
        step();
        d_in_valid = 1'b1; d_in_data = 24'h445566;
        step();
        d_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_valid", d_out_valid, 1'b1);
            chk("mid_data",  d_out_data, post_rst[i]);
            chk("mid_idx",   d_idx, 32'(i));
            step();
        end
        @(negedge clk);
        chk("mid_drain", d_out_valid, 1'b0);

        // equal width: full-rate stream, then a stall
        for (int i = 0; i < 8; i++) eq_vals[i] = 24'($urandom) ^ 24'(i);
        step();
        for (int i = 0; i < 8; i++) begin
            e_in_valid = 1'b1;
            e_in_data  = eq_vals[i];
            step();
            @(negedge clk);
            chk("eq_valid", e_out_valid, 1'b1);
            chk("eq_data",  e_out_data, eq_vals[i]);
            chk("eq_ready", e_in_ready, 1'b1);
            chk("eq_idx",   e_idx, 1'b0);
        end
        w = 24'hDEAD01;
        e_in_data   = w;
        e_out_ready = 1'b0;
        #1;
        chk("eq_stall_ready", e_in_ready, 1'b0);
        step();
        @(negedge clk);
        chk("eq_stall_data", e_out_data, eq_vals[7]);
        e_out_ready = 1'b1;
        #1;
        chk("eq_release", e_in_ready, 1'b1);
        step();
        e_in_valid = 1'b0;
        @(negedge clk);
        chk("eq_next", e_out_data, w);
        step();
        @(negedge clk);
        chk("eq_drain", e_out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
